// File: rtl/keypad_entry_buffer.sv
//------------------------------------------------------------------------------
// keypad_entry_buffer
//   Builds a multi-digit BCD entry from decoded keypad codes. Digits shift
//   in, '*' erases the newest digit, '#' submits the entry onto a
//   valid/ready hold register. Letter keys A-D become one-cycle commands.
//   Optional feature: define KEYPAD_ENTRY_TIMEOUT_EN to clear a partial
//   entry after TIMEOUT_CYCLES of inactivity.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module keypad_entry_buffer #(
   parameter int MAX_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [3:0]                       key_code,
   input  logic                             key_clicked,
   output logic [4*MAX_DIGITS-1:0]          live_bcd,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  live_len,
   output logic [4*MAX_DIGITS-1:0]          entry_bcd,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  entry_len,
   output logic                             entry_valid,
   input  logic                             entry_ready,
   output logic [1:0]                       cmd_code,
   output logic                             cmd_valid,
   output logic                             overflow,
   output logic                             timeout
);

   localparam int                LEN_W    = $clog2(MAX_DIGITS + 1);
   localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(MAX_DIGITS);
   localparam logic [3:0]        KEY_STAR = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t                  state;
   logic                    click_d;
   logic                    is_digit;
   logic                    is_letter;
   logic [3:0]              digit_val;
   logic [4*MAX_DIGITS-1:0] shift_up;
   logic [4*MAX_DIGITS-1:0] shift_down;
   logic                    expired;

   // Key classification and the two shifted views of the live digits
   always_comb begin
      is_digit      = (key_code <= 4'd9);
      is_letter     = (key_code[3:2] == 2'b11);
      digit_val     = (key_code == 4'd9) ? 4'd0 : key_code + 4'd1;
      shift_up      = live_bcd << 4;
      shift_up[3:0] = digit_val;
      shift_down    = live_bcd >> 4;
   end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] idle_cnt;

   assign expired = (idle_cnt == CNT_LAST);

   // Idle-cycle counter: runs only while a partial entry is open
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if (click_d || (state != S_ENTRY) || expired) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_timeout_cfg;

   assign expired            = 1'b0;
   assign timeout            = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

   // Entry state machine with registered live/entry/pulse outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         click_d     <= 1'b0;
         live_bcd    <= '0;
         live_len    <= '0;
         entry_bcd   <= '0;
         entry_len   <= '0;
         entry_valid <= 1'b0;
         cmd_code    <= 2'd0;
         cmd_valid   <= 1'b0;
         overflow    <= 1'b0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
         timeout     <= 1'b0;
`endif
      end else begin
         click_d   <= key_clicked;
         cmd_valid <= 1'b0;
         overflow  <= 1'b0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
         timeout   <= 1'b0;
`endif
         // A key decoded in the handshake cycle still sees HOLD below
         if ((state == S_HOLD) && entry_ready) begin
            entry_valid <= 1'b0;
            state       <= S_IDLE;
         end

         if (click_d) begin
            if (is_letter) begin
               cmd_valid <= 1'b1;
               cmd_code  <= key_code[1:0];
            end else if (state == S_HOLD) begin
               overflow <= 1'b1;
            end else if (is_digit) begin
               if (live_len == FULL_LEN) begin
                  overflow <= 1'b1;
               end else begin
                  live_bcd <= shift_up;
                  live_len <= live_len + LEN_W'(1);
                  state    <= S_ENTRY;
               end
            end else if (key_code == KEY_STAR) begin
               if (state == S_ENTRY) begin
                  live_bcd <= shift_down;
                  live_len <= live_len - LEN_W'(1);
                  if (live_len == LEN_W'(1)) begin
                     state <= S_IDLE;
                  end
               end
            end else begin
               if (state == S_ENTRY) begin
                  entry_bcd   <= live_bcd;
                  entry_len   <= live_len;
                  entry_valid <= 1'b1;
                  live_bcd    <= '0;
                  live_len    <= '0;
                  state       <= S_HOLD;
               end
            end
         end else if ((state == S_ENTRY) && expired) begin
            live_bcd <= '0;
            live_len <= '0;
            state    <= S_IDLE;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
            timeout  <= 1'b1;
`endif
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry_buffer.sv
//------------------------------------------------------------------------------
// tb_keypad_entry_buffer
//   Bench for keypad_entry_buffer (MAX_DIGITS=4, TIMEOUT_CYCLES=16) with a
//   queue-based reference model and directed plus randomized scenarios.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_entry_buffer;

   localparam int MAXD = 4;
   localparam int TO   = 16;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        key_clicked = 1'b0;
   logic        entry_ready = 1'b0;
   logic [15:0] live_bcd, entry_bcd;
   logic [2:0]  live_len, entry_len;
   logic        entry_valid, cmd_valid, overflow, timeout;
   logic [1:0]  cmd_code;

   int vectors = 0;
   int miscompares = 0;
   int ovf_seen = 0, cmd_seen = 0, to_seen = 0, ev_cycles = 0;

   // Reference model: digits kept as a queue, newest at the front
   int q[$];
   int ent[$];
   bit m_ev, m_click_d, m_cmd_v, m_ovf, m_to;
   int m_cmd_code, m_idle;

   keypad_entry_buffer #(.MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .key_code(key_code), .key_clicked(key_clicked),
      .live_bcd(live_bcd), .live_len(live_len), .entry_bcd(entry_bcd),
      .entry_len(entry_len), .entry_valid(entry_valid), .entry_ready(entry_ready),
      .cmd_code(cmd_code), .cmd_valid(cmd_valid), .overflow(overflow), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_live();
      logic [15:0] r;
      r = '0;
      foreach (q[i]) r[4*i +: 4] = 4'(q[i]);
      return r;
   endfunction

   function automatic logic [15:0] exp_entry();
      logic [15:0] r;
      r = '0;
      foreach (ent[i]) r[4*i +: 4] = 4'(ent[i]);
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      ent.delete();
      m_ev = 0; m_click_d = 0; m_cmd_v = 0; m_ovf = 0; m_to = 0;
      m_cmd_code = 0; m_idle = 0;
   endtask

   task automatic model_edge();
      bit hs;
      int k;
      hs = m_ev && entry_ready;
      k  = int'(key_code);
      m_cmd_v = 0; m_ovf = 0; m_to = 0;
      if (m_click_d) begin
         m_idle = 0;
         if (k >= 12) begin
            m_cmd_v = 1; m_cmd_code = k - 12;
         end else if (m_ev) begin
            m_ovf = 1;
         end else if (k <= 9) begin
            if (q.size() == MAXD) m_ovf = 1;
            else q.push_front((k == 9) ? 0 : k + 1);
         end else if (k == 10) begin
            if (q.size() > 0) void'(q.pop_front());
         end else if (q.size() > 0) begin
            ent = q; q.delete(); m_ev = 1;
         end
      end else if (TIMEOUT_ON && q.size() > 0) begin
         if (m_idle == TO - 1) begin
            q.delete(); m_to = 1; m_idle = 0;
         end else begin
            m_idle++;
         end
      end
      if (hs) m_ev = 0;
      m_click_d = key_clicked;
   endtask

   // One clock: advance the model at the edge, then observe pulses
   task automatic step();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_edge();
      #1;
      if (overflow) ovf_seen++;
      if (cmd_valid) cmd_seen++;
      if (timeout) to_seen++;
      if (entry_valid) ev_cycles++;
   endtask

   // Strobe, present the code one cycle later, then idle to fill 'gap' cycles
   task automatic press(input logic [3:0] code, input int gap);
      key_clicked = 1'b1; key_code = 4'($urandom);
      step();
      key_clicked = 1'b0; key_code = code;
      step();
      key_code = 4'($urandom);
      repeat (gap - 2) step();
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; key_clicked = 1'b0; entry_ready = 1'b0;
      step(); step();
      reset_n = 1'b1;
      ovf_seen = 0; cmd_seen = 0; to_seen = 0; ev_cycles = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step(); step();
      vectors++;
      if ({live_bcd, live_len, entry_bcd, entry_len, entry_valid, cmd_code, cmd_valid, overflow, timeout} !== 45'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want 0", {live_bcd, live_len, entry_bcd, entry_len, entry_valid, cmd_code, cmd_valid, overflow, timeout});
      end
      reset_n = 1'b1;
      step(); step();
      vectors++;
      if ({live_bcd, live_len, entry_valid, cmd_valid, overflow, timeout} !== 23'd0) begin
         miscompares++;
         $display("FAIL reset_release_idle: got %h want 0", {live_bcd, live_len, entry_valid, cmd_valid, overflow, timeout});
      end
   endtask

   task automatic test_digit_submit();
      apply_reset();
      press(4'd0, 5);
      vectors++;
      if (live_bcd !== 16'h0001) begin miscompares++; $display("FAIL live_after_1: got %h want 0001", live_bcd); end
      press(4'd1, 5);
      vectors++;
      if (live_bcd !== 16'h0012) begin miscompares++; $display("FAIL live_after_12: got %h want 0012", live_bcd); end
      press(4'd2, 5);
      vectors++;
      if (live_bcd !== 16'h0123 || live_len !== 3'd3) begin
         miscompares++; $display("FAIL live_after_123: got %h/%0d want 0123/3", live_bcd, live_len);
      end
      ev_cycles = 0;
      press(4'd11, 2);
      vectors++;
      if (entry_valid !== 1'b1 || entry_bcd !== 16'h0123 || entry_len !== 3'd3) begin
         miscompares++; $display("FAIL submit_t2: got v=%b %h/%0d want v=1 0123/3", entry_valid, entry_bcd, entry_len);
      end
      repeat (9) step();
      entry_ready = 1'b1;
      step();
      entry_ready = 1'b0;
      vectors++;
      if (ev_cycles !== 10 || entry_valid !== 1'b0) begin
         miscompares++; $display("FAIL hold_width: got %0d cycles v=%b want 10 v=0", ev_cycles, entry_valid);
      end
      vectors++;
      if (entry_bcd !== 16'h0123 || entry_len !== 3'd3 || live_len !== 3'd0) begin
         miscompares++; $display("FAIL after_handshake: got %h/%0d live_len=%0d want 0123/3 0", entry_bcd, entry_len, live_len);
      end
      press(4'd6, 5);
      vectors++;
      if (live_bcd !== 16'h0007 || live_len !== 3'd1) begin
         miscompares++; $display("FAIL idle_after_hold: got %h/%0d want 0007/1", live_bcd, live_len);
      end
   endtask

   task automatic test_overflow_backspace();
      apply_reset();
      press(4'd8, 5); press(4'd7, 5); press(4'd6, 5); press(4'd5, 5);
      press(4'd4, 5);
      vectors++;
      if (live_bcd !== 16'h9876 || live_len !== 3'd4 || ovf_seen !== 1) begin
         miscompares++; $display("FAIL overflow: got %h/%0d ovf=%0d want 9876/4 ovf=1", live_bcd, live_len, ovf_seen);
      end
      press(4'd10, 5);
      vectors++;
      if (live_bcd !== 16'h0987 || live_len !== 3'd3) begin
         miscompares++; $display("FAIL backspace: got %h/%0d want 0987/3", live_bcd, live_len);
      end
      press(4'd10, 5); press(4'd10, 5); press(4'd10, 5);
      vectors++;
      if (live_bcd !== 16'h0000 || live_len !== 3'd0 || ovf_seen !== 1) begin
         miscompares++; $display("FAIL backspace_to_empty: got %h/%0d ovf=%0d want 0000/0 ovf=1", live_bcd, live_len, ovf_seen);
      end
   endtask

   task automatic test_empty_ops();
      apply_reset();
      press(4'd11, 5);
      press(4'd10, 5);
      vectors++;
      if ({live_bcd, live_len, entry_bcd, entry_len, entry_valid, cmd_code, cmd_valid, overflow, timeout} !== 45'd0
          || ovf_seen !== 0 || ev_cycles !== 0) begin
         miscompares++;
         $display("FAIL empty_ops: got ovf=%0d ev=%0d live=%h entry=%h want all 0", ovf_seen, ev_cycles, live_bcd, entry_bcd);
      end
   endtask

   task automatic test_letters_in_hold();
      apply_reset();
      press(4'd2, 5);
      press(4'd11, 5);
      press(4'd9, 5);
      vectors++;
      if (ovf_seen !== 1 || entry_bcd !== 16'h0003 || entry_len !== 3'd1 || live_len !== 3'd0) begin
         miscompares++; $display("FAIL hold_drop_digit: got ovf=%0d %h/%0d live_len=%0d want 1 0003/1 0", ovf_seen, entry_bcd, entry_len, live_len);
      end
      press(4'd14, 5);
      vectors++;
      if (cmd_seen !== 1 || cmd_code !== 2'd2 || ovf_seen !== 1) begin
         miscompares++; $display("FAIL hold_letter: got cmd=%0d code=%0d ovf=%0d want 1 2 1", cmd_seen, cmd_code, ovf_seen);
      end
      vectors++;
      if (entry_valid !== 1'b1 || entry_bcd !== 16'h0003) begin
         miscompares++; $display("FAIL hold_entry_stable: got v=%b %h want v=1 0003", entry_valid, entry_bcd);
      end
      entry_ready = 1'b1;
      step();
      entry_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int waited;
      apply_reset();
      press(4'd3, 2);
      waited = 0;
      for (int i = 1; i <= 24 && to_seen == 0; i++) begin
         step();
         waited = i;
      end
      vectors++;
      if (!TIMEOUT_ON) begin
         if (to_seen !== 0 || live_bcd !== 16'h0004) begin
            miscompares++; $display("FAIL no_timeout_build: got to=%0d %h want 0 0004", to_seen, live_bcd);
         end
      end else if (waited !== 16 || to_seen !== 1 || live_len !== 3'd0 || live_bcd !== 16'h0000) begin
         miscompares++; $display("FAIL timeout: got at %0d to=%0d %h/%0d want 16 1 0000/0", waited, to_seen, live_bcd, live_len);
      end
      apply_reset();
      press(4'd3, 2);
      repeat (14) step();
      press(4'd6, 2);
      vectors++;
      if (to_seen !== 0 || live_bcd !== 16'h0047 || live_len !== 3'd2) begin
         miscompares++; $display("FAIL key_beats_timeout: got to=%0d %h/%0d want 0 0047/2", to_seen, live_bcd, live_len);
      end
      waited = 0;
      for (int i = 1; i <= 24 && to_seen == 0; i++) begin
         step();
         waited = i;
      end
      vectors++;
      if (TIMEOUT_ON && (waited !== 16 || live_len !== 3'd0)) begin
         miscompares++; $display("FAIL timeout_restart: got at %0d len=%0d want 16 0", waited, live_len);
      end else if (!TIMEOUT_ON && to_seen !== 0) begin
         miscompares++; $display("FAIL no_timeout_build2: got to=%0d want 0", to_seen);
      end
   endtask

   task automatic test_reset_mid_hold();
      apply_reset();
      press(4'd0, 5);
      press(4'd11, 5);
      vectors++;
      if (entry_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_hold: got v=%b want 1", entry_valid); end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if ({live_bcd, live_len, entry_bcd, entry_len, entry_valid, cmd_code, cmd_valid, overflow, timeout} !== 45'd0) begin
         miscompares++;
         $display("FAIL async_reset: got %h want 0", {live_bcd, live_len, entry_bcd, entry_len, entry_valid, cmd_code, cmd_valid, overflow, timeout});
      end
      model_reset();
      step();
      reset_n = 1'b1;
      step();
      vectors++;
      if (entry_valid !== 1'b0 || entry_len !== 3'd0) begin
         miscompares++; $display("FAIL entry_lost: got v=%b len=%0d want 0 0", entry_valid, entry_len);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      key_clicked = 1'b1; key_code = 4'($urandom);
      step();
      key_code = 4'd4;
      step();
      vectors++;
      if (live_bcd !== 16'h0005) begin miscompares++; $display("FAIL b2b_first: got %h want 0005", live_bcd); end
      key_clicked = 1'b0; key_code = 4'd5;
      step();
      key_code = 4'($urandom);
      vectors++;
      if (live_bcd !== 16'h0056 || live_len !== 3'd2) begin
         miscompares++; $display("FAIL b2b_second: got %h/%0d want 0056/2", live_bcd, live_len);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         if ((c % 300) >= 250) key_clicked = 1'b0;
         else key_clicked = ($urandom_range(0, 2) == 0);
         key_code    = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
         entry_ready = ($urandom_range(0, 3) == 0);
         step();
         vectors++;
         if ({live_bcd, live_len, entry_bcd, entry_len, entry_valid, cmd_code, cmd_valid, overflow, timeout}
             !== {exp_live(), 3'(q.size()), exp_entry(), 3'(ent.size()), m_ev, 2'(m_cmd_code), m_cmd_v, m_ovf, m_to}) begin
            miscompares++;
            $display("FAIL random_cycle_%0d: got %h want %h", c,
                     {live_bcd, live_len, entry_bcd, entry_len, entry_valid, cmd_code, cmd_valid, overflow, timeout},
                     {exp_live(), 3'(q.size()), exp_entry(), 3'(ent.size()), m_ev, 2'(m_cmd_code), m_cmd_v, m_ovf, m_to});
         end
      end
      key_clicked = 1'b0;
      entry_ready = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_digit_submit();
      test_overflow_backspace();
      test_empty_ops();
      test_letters_in_hold();
      test_timeout();
      test_reset_mid_hold();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Downstream consumer of the keypad decode stage. Turns the stream of decoded key codes into a multi-digit BCD entry: digits 0–9 shift in, `*` erases the last digit, `#` submits. A–D are passed through as one-cycle command pulses. Submitted entries are held on a valid/ready handshake for the application logic (display, comparator, controller).

## Interface
- `MAX_DIGITS`, default 4: entry capacity in digits; legal range 1–8.
- `TIMEOUT_CYCLES`, default 100_000_000: inactivity limit for a partial entry (1 s at 100 MHz); minimum 2.
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `key_code`, in, 4: decoded key.
  - 0000–1000 = digits 1–9; 1001 = 0; 1010 = `*`; 1011 = `#`; 1100–1111 = A–D.
- `key_clicked`, in, 1: one-cycle strobe; the matching `key_code` is valid on the cycle after the strobe.
- `live_bcd`, out, 4*MAX_DIGITS: digits typed so far; nibble 0 = most recent; unused nibbles 0.
- `live_len`, out, $clog2(MAX_DIGITS+1): number of digits in `live_bcd`.
- `entry_bcd`, out, 4*MAX_DIGITS: submitted entry; stable while `entry_valid` is high.
- `entry_len`, out, $clog2(MAX_DIGITS+1): digit count of the submitted entry.
- `entry_valid`, out, 1: submitted entry available.
- `entry_ready`, in, 1: consumer accepts the entry.
- `cmd_code`, out, 2: letter key, A=0 … D=3.
- `cmd_valid`, out, 1: one-cycle pulse per letter key.
- `overflow`, out, 1: one-cycle pulse when a key is dropped (see below).
- `timeout`, out, 1: one-cycle pulse when a partial entry is cleared for inactivity.

## Operation
- **Click pipeline:** `key_clicked` is registered as `click_d`. On the cycle `click_d` is high, `key_code` is decoded. Back-to-back strobes are each processed, one cycle apart.
- **States:** IDLE (`live_len`=0), ENTRY (`live_len`>0), HOLD (`entry_valid`=1).
- **Digit, IDLE/ENTRY, `live_len`<MAX_DIGITS:**
  - `live_bcd` shifts up one nibble; the new digit goes into nibble 0; `live_len`+1.
  - IDLE→ENTRY.
- **Digit at `live_len`=MAX_DIGITS:** ignored; `overflow` pulses.
- **`*`:**
  - ENTRY: `live_bcd` shifts down one nibble, top nibble becomes 0, `live_len`−1. ENTRY→IDLE if the count reaches 0.
  - IDLE: no effect.
- **`#`:**
  - ENTRY: copy `live_bcd`/`live_len` to `entry_bcd`/`entry_len`; clear live; go to HOLD.
  - IDLE: no effect.
- **HOLD:**
  - Digit, `*` and `#` are dropped and pulse `overflow`; live registers stay 0.
  - Leaves HOLD to IDLE on the cycle `entry_valid && entry_ready`.
- **Letter keys:** in any state, `cmd_valid` pulses and `cmd_code` = `key_code`−12. Never dropped; no effect on entry state.
- **Inactivity counter:**
  - Runs only in ENTRY. Zeroed on every decoded key and on any exit from ENTRY.
  - When the count reaches TIMEOUT_CYCLES−1: clear live registers, go to IDLE, pulse `timeout`.
  - A key decoded in that same cycle wins: the key is processed and no timeout occurs.

## Timing
- **Reset values:** all outputs 0; state IDLE; counter 0; `click_d` 0.
- **Latency:** strobe at cycle t → decode at t+1 → `live_*`, `entry_*`, `cmd_valid`, `overflow` visible at t+2.
- **`entry_valid`:**
  - Rises at t+2 for `#` strobed at t.
  - Holds, with `entry_bcd`/`entry_len` unchanged, until sampled high together with `entry_ready`.
  - Falls the following cycle.
  - `entry_bcd`/`entry_len` retain their value after the handshake until the next submit.
- **`entry_ready`:** may be held high permanently. Minimum HOLD duration is then one cycle.
- **Handshake and key in the same cycle:** a strobe decoded in the handshake cycle is still treated as in HOLD, so it is dropped (letters excepted).
- **Reset mid-entry or mid-HOLD:** everything cleared immediately; an unaccepted entry is lost.
- **Pulse outputs** (`cmd_valid`, `overflow`, `timeout`): exactly one cycle wide.

## Configuration
- Macro: `KEYPAD_ENTRY_TIMEOUT_EN`.
- **Defined:** inactivity counter present; behaviour as above.
- **Undefined:**
  - Counter and `TIMEOUT_CYCLES` logic are removed.
  - `timeout` is tied to 0.
  - A partial entry persists until `*`, `#` or reset.

## Test plan
Bench configuration: MAX_DIGITS=4, TIMEOUT_CYCLES=16, macro defined. Strobes are spaced 5 cycles apart unless stated.
- **Digit entry and submit:** keys 1,2,3 (codes 0000, 0001, 0010), then `#`, with `entry_ready`=0 for 10 cycles → `live_bcd` passes through 0x0001, 0x0012, 0x0123. `entry_bcd`=0x0123, `entry_len`=3; `entry_valid` rises 2 cycles after the `#` strobe and stays high 10 cycles. After the `entry_ready` handshake, state is IDLE.
- **Overflow and backspace:** 9,8,7,6,5 → `live_bcd`=0x9876; one `overflow` pulse. Then `*` → 0x0987, `live_len`=3.
- **Submit/backspace on empty:** `#` and `*` in IDLE → no `entry_valid`, no `overflow`; all outputs stay 0.
- **Letters in HOLD:** hold an entry with `entry_ready`=0, press digit 0 (code 1001) then C (1110) → the digit is dropped with an `overflow` pulse; `cmd_valid` pulses with `cmd_code`=2; `entry_bcd` unchanged.
- **Timeout:** press 4, then idle → `timeout` pulses 16 cycles after the decode; `live_len`=0. A repeat with a key at cycle 15 produces no timeout.
- **Reset mid-HOLD and back-to-back strobes:** assert `reset_n`=0 while in HOLD → all outputs 0 asynchronously. Strobes on consecutive cycles for 5 then 6 → `live_bcd`=0x0056.
